// File: rtl/hemaia_mem_pkg.sv
// Shared types and sizing helpers for the HEMAiA main-memory super-bank arbiter.
package hemaia_mem_pkg;

  typedef enum logic {
    OWN_NARROW = 1'b0,
    OWN_WIDE   = 1'b1
  } owner_e;

  localparam int unsigned StarveCntWidth = 3;

  function automatic int unsigned BanksPerSuperBank(input int unsigned wide_w,
                                                    input int unsigned narrow_w);
    return wide_w / narrow_w;
  endfunction

  // Counter must hold MaxStarve-1 but never shrinks below the base width.
  function automatic int unsigned StarveCntBits(input int unsigned max_starve);
    int unsigned need;
    need = $clog2(max_starve + 1);
    return (need > StarveCntWidth) ? need : StarveCntWidth;
  endfunction

endpackage

// File: rtl/hemaia_sb_lane.sv
// One bank lane of a super-bank: selects the request fields driving the bank and
// steers the bank read data back to whichever port owns the returning response.
module hemaia_sb_lane #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 10
) (
  input  logic            grant_wide_i,
  input  logic            wide_we_i,
  input  logic [AW-1:0]   wide_addr_i,
  input  logic [DW-1:0]   wide_wdata_i,
  input  logic [DW/8-1:0] wide_strb_i,
  input  logic            narrow_valid_i,
  input  logic            narrow_we_i,
  input  logic [AW-1:0]   narrow_addr_i,
  input  logic [DW-1:0]   narrow_wdata_i,
  input  logic [DW/8-1:0] narrow_strb_i,
  input  logic            wide_rvalid_i,
  input  logic            narrow_rvalid_i,
  input  logic [DW-1:0]   bank_rdata_i,
  output logic            bank_cs_o,
  output logic            bank_we_o,
  output logic [AW-1:0]   bank_addr_o,
  output logic [DW-1:0]   bank_wdata_o,
  output logic [DW/8-1:0] bank_be_o,
  output logic [DW-1:0]   wide_rdata_o,
  output logic [DW-1:0]   narrow_rdata_o
);

  // Bank request mux: wide owns every lane when granted, otherwise the lane's narrow port.
  always_comb begin
    bank_cs_o    = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = {AW{1'b0}};
    bank_wdata_o = {DW{1'b0}};
    bank_be_o    = {(DW/8){1'b0}};
    if (grant_wide_i) begin
      bank_cs_o    = 1'b1;
      bank_we_o    = wide_we_i;
      bank_addr_o  = wide_addr_i;
      bank_wdata_o = wide_wdata_i;
      bank_be_o    = wide_strb_i;
    end else if (narrow_valid_i) begin
      bank_cs_o    = 1'b1;
      bank_we_o    = narrow_we_i;
      bank_addr_o  = narrow_addr_i;
      bank_wdata_o = narrow_wdata_i;
      bank_be_o    = narrow_strb_i;
    end else begin
      bank_cs_o    = 1'b0;
    end
  end

  // Read data steering: zero unless the matching response is valid.
  always_comb begin
    wide_rdata_o   = {DW{1'b0}};
    narrow_rdata_o = {DW{1'b0}};
    if (wide_rvalid_i) begin
      wide_rdata_o = bank_rdata_i;
    end else begin
      wide_rdata_o = {DW{1'b0}};
    end
    if (narrow_rvalid_i) begin
      narrow_rdata_o = bank_rdata_i;
    end else begin
      narrow_rdata_o = {DW{1'b0}};
    end
  end

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Super-bank arbiter: wide priority with bounded narrow starvation, 1-cycle read return.
// Optional performance counters are built only when HEMAIA_SB_ARB_PERF_EN is defined.
module hemaia_superbank_arbiter
  import hemaia_mem_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned MaxStarve       = 4,
  localparam int unsigned N  = BanksPerSuperBank(WideDataWidth, NarrowDataWidth),
  localparam int unsigned BW = NarrowDataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wide_valid_i,
  output logic                         wide_ready_o,
  input  logic [AddrWidth-1:0]         wide_addr_i,
  input  logic                         wide_we_i,
  input  logic [WideDataWidth-1:0]     wide_wdata_i,
  input  logic [WideDataWidth/8-1:0]   wide_strb_i,
  output logic                         wide_rvalid_o,
  output logic [WideDataWidth-1:0]     wide_rdata_o,
  input  logic [N-1:0]                 narrow_valid_i,
  output logic [N-1:0]                 narrow_ready_o,
  input  logic [N*AddrWidth-1:0]       narrow_addr_i,
  input  logic [N-1:0]                 narrow_we_i,
  input  logic [N*NarrowDataWidth-1:0] narrow_wdata_i,
  input  logic [N*BW-1:0]              narrow_strb_i,
  output logic [N-1:0]                 narrow_rvalid_o,
  output logic [N*NarrowDataWidth-1:0] narrow_rdata_o,
  output logic [N-1:0]                 bank_cs_o,
  output logic [N-1:0]                 bank_we_o,
  output logic [N*AddrWidth-1:0]       bank_addr_o,
  output logic [N*NarrowDataWidth-1:0] bank_wdata_o,
  output logic [N*BW-1:0]              bank_be_o,
  input  logic [N*NarrowDataWidth-1:0] bank_rdata_i,
  output logic [31:0]                  perf_wide_cnt_o,
  output logic [31:0]                  perf_block_cnt_o
);

  localparam int unsigned CW = StarveCntBits(MaxStarve);
  localparam logic [CW-1:0] CntLast = (MaxStarve > 0) ? CW'(MaxStarve - 1) : {CW{1'b0}};

  typedef enum logic {
    WIDE_PRIO    = 1'b0,
    FORCE_NARROW = 1'b1
  } arb_state_e;

  arb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  owner_e        own_q;
  logic [N-1:0]  rd_q;
  logic [N-1:0]  rd_d;
  logic          force_s;
  logic          narrow_any_s;
  logic          grant_wide_s;
  logic [N-1:0]  narrow_ready_s;
  logic [N-1:0]  bank_cs_s;
  logic [N-1:0]  bank_we_s;
  logic          wide_rvalid_s;
  logic [N-1:0]  narrow_rvalid_s;

  assign force_s        = (state_q == FORCE_NARROW);
  assign narrow_any_s   = |narrow_valid_i;
  assign grant_wide_s   = wide_valid_i & ~(force_s & narrow_any_s);
  assign narrow_ready_s = narrow_valid_i & ~{N{grant_wide_s}};
  assign rd_d           = bank_cs_s & ~bank_we_s;

  assign wide_ready_o    = grant_wide_s;
  assign narrow_ready_o  = narrow_ready_s;
  assign bank_cs_o       = bank_cs_s;
  assign bank_we_o       = bank_we_s;
  assign wide_rvalid_s   = (own_q == OWN_WIDE) & rd_q[0];
  assign narrow_rvalid_s = {N{own_q == OWN_NARROW}} & rd_q;
  assign wide_rvalid_o   = wide_rvalid_s;
  assign narrow_rvalid_o = narrow_rvalid_s;

  // Starvation FSM: after MaxStarve wide grants that blocked narrow, hand one cycle to narrow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WIDE_PRIO;
      cnt_q   <= {CW{1'b0}};
    end else if (MaxStarve == 0) begin
      state_q <= WIDE_PRIO;
      cnt_q   <= {CW{1'b0}};
    end else begin
      case (state_q)
        WIDE_PRIO: begin
          if (grant_wide_s && narrow_any_s) begin
            if (cnt_q == CntLast) begin
              state_q <= FORCE_NARROW;
              cnt_q   <= {CW{1'b0}};
            end else if (cnt_q != {CW{1'b1}}) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              cnt_q <= cnt_q;
            end
          end else begin
            cnt_q <= {CW{1'b0}};
          end
        end
        FORCE_NARROW: begin
          state_q <= WIDE_PRIO;
          cnt_q   <= {CW{1'b0}};
        end
        default: begin
          state_q <= WIDE_PRIO;
          cnt_q   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Response bookkeeping: remember the owner and which lanes issued a read this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q <= OWN_NARROW;
      rd_q  <= {N{1'b0}};
    end else begin
      own_q <= grant_wide_s ? OWN_WIDE : OWN_NARROW;
      rd_q  <= rd_d;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    hemaia_sb_lane #(
      .DW(NarrowDataWidth),
      .AW(AddrWidth)
    ) u_lane (
      .grant_wide_i   (grant_wide_s),
      .wide_we_i      (wide_we_i),
      .wide_addr_i    (wide_addr_i),
      .wide_wdata_i   (wide_wdata_i[j*NarrowDataWidth +: NarrowDataWidth]),
      .wide_strb_i    (wide_strb_i[j*BW +: BW]),
      .narrow_valid_i (narrow_valid_i[j]),
      .narrow_we_i    (narrow_we_i[j]),
      .narrow_addr_i  (narrow_addr_i[j*AddrWidth +: AddrWidth]),
      .narrow_wdata_i (narrow_wdata_i[j*NarrowDataWidth +: NarrowDataWidth]),
      .narrow_strb_i  (narrow_strb_i[j*BW +: BW]),
      .wide_rvalid_i  (wide_rvalid_s),
      .narrow_rvalid_i(narrow_rvalid_s[j]),
      .bank_rdata_i   (bank_rdata_i[j*NarrowDataWidth +: NarrowDataWidth]),
      .bank_cs_o      (bank_cs_s[j]),
      .bank_we_o      (bank_we_s[j]),
      .bank_addr_o    (bank_addr_o[j*AddrWidth +: AddrWidth]),
      .bank_wdata_o   (bank_wdata_o[j*NarrowDataWidth +: NarrowDataWidth]),
      .bank_be_o      (bank_be_o[j*BW +: BW]),
      .wide_rdata_o   (wide_rdata_o[j*NarrowDataWidth +: NarrowDataWidth]),
      .narrow_rdata_o (narrow_rdata_o[j*NarrowDataWidth +: NarrowDataWidth])
    );
  end

`ifdef HEMAIA_SB_ARB_PERF_EN
  logic [31:0] perf_wide_q;
  logic [31:0] perf_block_q;
  logic        block_s;

  assign block_s = |(narrow_valid_i & ~narrow_ready_s);

  // Saturating counters of wide grants and of cycles with a blocked narrow lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_wide_q  <= 32'h0;
      perf_block_q <= 32'h0;
    end else begin
      if (grant_wide_s && (perf_wide_q != 32'hFFFF_FFFF)) begin
        perf_wide_q <= perf_wide_q + 32'd1;
      end else begin
        perf_wide_q <= perf_wide_q;
      end
      if (block_s && (perf_block_q != 32'hFFFF_FFFF)) begin
        perf_block_q <= perf_block_q + 32'd1;
      end else begin
        perf_block_q <= perf_block_q;
      end
    end
  end

  assign perf_wide_cnt_o  = perf_wide_q;
  assign perf_block_cnt_o = perf_block_q;
`else
  assign perf_wide_cnt_o  = 32'h0;
  assign perf_block_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// Bench for hemaia_superbank_arbiter: two instances (MaxStarve=4 and 0) share stimulus and
// are checked each cycle against a transaction-level model plus hand-computed literals.
module tb_hemaia_superbank_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wvalid, wwe;
  logic [9:0]   waddr;
  logic [511:0] wwd;
  logic [63:0]  wstrb;
  logic [7:0]   nvalid, nwe;
  logic [79:0]  naddr;
  logic [511:0] nwd;
  logic [63:0]  nstrb;

  logic         wready [2];
  logic         wrv    [2];
  logic [511:0] wrd    [2];
  logic [7:0]   nready [2];
  logic [7:0]   nrv    [2];
  logic [511:0] nrd    [2];
  logic [7:0]   bcs    [2];
  logic [7:0]   bwe    [2];
  logic [79:0]  baddr  [2];
  logic [511:0] bwd    [2];
  logic [63:0]  bbe    [2];
  logic [511:0] brd    [2];
  logic [31:0]  pw_o   [2];
  logic [31:0]  pb_o   [2];

  logic [63:0]  mem     [2][8][1024];
  logic [63:0]  ref_mem [2][8][1024];

  int           streak [2];
  logic         pw     [2];
  logic [7:0]   pn     [2];
  logic [511:0] pwd    [2];
  logic [511:0] pnd    [2];
  int unsigned  mw     [2];
  int unsigned  mb     [2];

  logic         s_wready [2];
  logic         s_wrv    [2];
  logic [7:0]   s_nready [2];
  logic [7:0]   s_nrv    [2];
  logic [7:0]   s_bcs    [2];
  logic [511:0] s_wrd    [2];
  logic [511:0] s_nrd    [2];
  logic [63:0]  s_bbe    [2];
  logic [31:0]  s_pw     [2];
  logic [31:0]  s_pb     [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    hemaia_superbank_arbiter #(.MaxStarve((k == 0) ? 4 : 0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wide_valid_i(wvalid), .wide_ready_o(wready[k]), .wide_addr_i(waddr),
      .wide_we_i(wwe), .wide_wdata_i(wwd), .wide_strb_i(wstrb),
      .wide_rvalid_o(wrv[k]), .wide_rdata_o(wrd[k]),
      .narrow_valid_i(nvalid), .narrow_ready_o(nready[k]), .narrow_addr_i(naddr),
      .narrow_we_i(nwe), .narrow_wdata_i(nwd), .narrow_strb_i(nstrb),
      .narrow_rvalid_o(nrv[k]), .narrow_rdata_o(nrd[k]),
      .bank_cs_o(bcs[k]), .bank_we_o(bwe[k]), .bank_addr_o(baddr[k]),
      .bank_wdata_o(bwd[k]), .bank_be_o(bbe[k]), .bank_rdata_i(brd[k]),
      .perf_wide_cnt_o(pw_o[k]), .perf_block_cnt_o(pb_o[k])
    );
  end

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic int ms(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Behavioural SRAM banks: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++)
        if (bcs[k][j]) begin
          if (bwe[k][j])
            mem[k][j][baddr[k][j*10 +: 10]] <= merge(mem[k][j][baddr[k][j*10 +: 10]],
                                                     bwd[k][j*64 +: 64], bbe[k][j*8 +: 8]);
          else
            brd[k][j*64 +: 64] <= mem[k][j][baddr[k][j*10 +: 10]];
        end
  end

  task automatic chk(input string nm, input int k, input logic [511:0] act,
                     input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      streak[k] = 0; pw[k] = 1'b0; pn[k] = 8'h00; mw[k] = 0; mb[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic         gw, frc, anyn;
      logic [7:0]   nrdy, cs, we_e;
      logic [79:0]  ad_e;
      logic [511:0] wd_e, nrd_e;
      logic [63:0]  be_e;
      logic [31:0]  epw, epb;
      anyn = |nvalid;
      frc  = (ms(k) > 0) && (streak[k] == ms(k)) && anyn;
      gw   = wvalid && !frc;
      nrdy = gw ? 8'h00 : nvalid;
      cs   = gw ? 8'hFF : nvalid;
      we_e = 8'h00; ad_e = 80'h0; wd_e = 512'h0; be_e = 64'h0; nrd_e = 512'h0;
      for (int j = 0; j < 8; j++) begin
        if (cs[j]) begin
          we_e[j]          = gw ? wwe : nwe[j];
          ad_e[j*10 +: 10] = gw ? waddr : naddr[j*10 +: 10];
          wd_e[j*64 +: 64] = gw ? wwd[j*64 +: 64] : nwd[j*64 +: 64];
          be_e[j*8 +: 8]   = gw ? wstrb[j*8 +: 8] : nstrb[j*8 +: 8];
        end
        if (pn[k][j]) nrd_e[j*64 +: 64] = pnd[k][j*64 +: 64];
      end
`ifdef HEMAIA_SB_ARB_PERF_EN
      epw = mw[k]; epb = mb[k];
`else
      epw = 32'h0; epb = 32'h0;
`endif
      s_wready[k] = wready[k]; s_wrv[k] = wrv[k]; s_nready[k] = nready[k]; s_nrv[k] = nrv[k];
      s_bcs[k] = bcs[k]; s_wrd[k] = wrd[k]; s_nrd[k] = nrd[k]; s_bbe[k] = bbe[k];
      s_pw[k] = pw_o[k]; s_pb[k] = pb_o[k];
      chk("wide_ready", k, wready[k], gw);
      chk("narrow_ready", k, nready[k], nrdy);
      chk("bank_cs", k, bcs[k], cs);
      chk("bank_we", k, bwe[k], we_e);
      chk("bank_addr", k, baddr[k], ad_e);
      chk("bank_wdata", k, bwd[k], wd_e);
      chk("bank_be", k, bbe[k], be_e);
      chk("wide_rvalid", k, wrv[k], pw[k]);
      chk("wide_rdata", k, wrd[k], pw[k] ? pwd[k] : 512'h0);
      chk("narrow_rvalid", k, nrv[k], pn[k]);
      chk("narrow_rdata", k, nrd[k], nrd_e);
      chk("perf_wide", k, pw_o[k], epw);
      chk("perf_block", k, pb_o[k], epb);
      // advance the model to the next cycle
      if (ms(k) > 0) streak[k] = (gw && anyn) ? streak[k] + 1 : 0;
      if (gw) mw[k]++;
      if (|(nvalid & ~nrdy)) mb[k]++;
      pw[k] = gw && !wwe;
      pn[k] = gw ? 8'h00 : (nvalid & ~nwe);
      for (int j = 0; j < 8; j++) begin
        pwd[k][j*64 +: 64] = ref_mem[k][j][waddr];
        pnd[k][j*64 +: 64] = ref_mem[k][j][naddr[j*10 +: 10]];
        if (gw && wwe)
          ref_mem[k][j][waddr] = merge(ref_mem[k][j][waddr], wwd[j*64 +: 64], wstrb[j*8 +: 8]);
        else if (!gw && nvalid[j] && nwe[j])
          ref_mem[k][j][naddr[j*10 +: 10]] = merge(ref_mem[k][j][naddr[j*10 +: 10]],
                                                   nwd[j*64 +: 64], nstrb[j*8 +: 8]);
      end
    end
  endtask

  task automatic tick();
    #8;
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wvalid = 1'b0; wwe = 1'b0; waddr = 10'h0; wwd = 512'h0; wstrb = 64'h0;
    nvalid = 8'h0; nwe = 8'h0; naddr = 80'h0; nwd = 512'h0; nstrb = 64'h0;
  endtask

  task automatic set_lane(input int j, input logic v, input logic we, input logic [9:0] a,
                          input logic [63:0] d, input logic [7:0] s);
    nvalid[j] = v; nwe[j] = we; naddr[j*10 +: 10] = a; nwd[j*64 +: 64] = d; nstrb[j*8 +: 8] = s;
  endtask

  task automatic rst_cycle();
    idle();
    rst_n = 1'b0;
    #8;
    model_reset();
    check_all();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [511:0] lanes;
  logic [9:0]   pat [2];

  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++)
        for (int a = 0; a < 1024; a++) ref_mem[k][j][a] = 64'h0;
    for (int j = 0; j < 8; j++) lanes[j*64 +: 64] = 64'(j);
    model_reset();
    @(posedge clk);
    #1;
    rst_cycle();
    for (int k = 0; k < 2; k++) begin
      chk("lit_reset_rvalid", k, s_nrv[k], 8'h00);
      chk("lit_reset_perf", k, s_pb[k], 32'h0);
    end

    // wide write lane j = j, then wide read of the same word
    wvalid = 1'b1; wwe = 1'b1; waddr = 10'h012; wwd = lanes; wstrb = {64{1'b1}};
    tick();
    wwe = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) chk("lit_wide_ready", k, s_wready[k], 1'b1);
    idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("lit_wide_rvalid", k, s_wrv[k], 1'b1);
      chk("lit_wide_rdata", k, s_wrd[k], lanes);
    end

    // narrow lane 3 partial write and readback
    set_lane(3, 1'b1, 1'b1, 10'h040, 64'h0, 8'hFF);
    tick();
    set_lane(3, 1'b1, 1'b1, 10'h040, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("lit_lane3_cs", k, s_bcs[k], 8'h08);
      chk("lit_lane3_be", k, s_bbe[k][31:24], 8'h0F);
    end
    set_lane(3, 1'b1, 1'b0, 10'h040, 64'h0, 8'h00);
    tick();
    for (int k = 0; k < 2; k++) chk("lit_write_no_rvalid", k, s_nrv[k], 8'h00);
    idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("lit_lane3_rvalid", k, s_nrv[k], 8'h08);
      chk("lit_lane3_rdata", k, s_nrd[k][255:192], 64'h0000_0000_DEAD_BEEF);
    end

    // lanes 1 and 5 read in the same cycle
    set_lane(1, 1'b1, 1'b1, 10'h021, 64'h1111_2222_3333_4444, 8'hFF);
    set_lane(5, 1'b1, 1'b1, 10'h035, 64'h5555_6666_7777_8888, 8'hFF);
    tick();
    set_lane(1, 1'b1, 1'b0, 10'h021, 64'h0, 8'h00);
    set_lane(5, 1'b1, 1'b0, 10'h035, 64'h0, 8'h00);
    tick();
    for (int k = 0; k < 2; k++) chk("lit_dual_ready", k, s_nready[k], 8'h22);
    idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("lit_dual_rvalid", k, s_nrv[k], 8'h22);
      chk("lit_dual_wide_rvalid", k, s_wrv[k], 1'b0);
      chk("lit_lane1_rdata", k, s_nrd[k][127:64], 64'h1111_2222_3333_4444);
      chk("lit_lane5_rdata", k, s_nrd[k][383:320], 64'h5555_6666_7777_8888);
    end

    // narrow read cut off by a reset pulse before its response
    set_lane(2, 1'b1, 1'b0, 10'h055, 64'h0, 8'h00);
    #2;
    rst_n = 1'b0;
    #6;
    model_reset();
    check_all();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    tick();
    for (int k = 0; k < 2; k++) chk("lit_rst_no_rvalid", k, s_nrv[k], 8'h00);
    wvalid = 1'b1; wwe = 1'b1; waddr = 10'h060; wwd = lanes; wstrb = {64{1'b1}};
    set_lane(0, 1'b1, 1'b1, 10'h061, 64'h77, 8'hFF);
    tick();
    for (int k = 0; k < 2; k++) chk("lit_rst_wide_first", k, s_wready[k], 1'b1);

    // continuous wide + narrow lane 0 contention
    rst_cycle();
    wvalid = 1'b1; wwe = 1'b1; waddr = 10'h070; wwd = lanes; wstrb = {64{1'b1}};
    set_lane(0, 1'b1, 1'b1, 10'h071, 64'hABCD, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int k = 0; k < 2; k++) pat[k][i] = s_nready[k][0];
    end
    idle();
    tick();
    chk("lit_starve4_pattern", 0, pat[0], 10'h210);
    chk("lit_starve0_pattern", 1, pat[1], 10'h000);
`ifdef HEMAIA_SB_ARB_PERF_EN
    chk("lit_perf_block", 0, s_pb[0], 32'd8);
    chk("lit_perf_block", 1, s_pb[1], 32'd10);
    chk("lit_perf_wide", 0, s_pw[0], 32'd8);
    chk("lit_perf_wide", 1, s_pw[1], 32'd10);
`else
    chk("lit_perf_block", 1, s_pb[1], 32'd0);
    chk("lit_perf_wide", 1, s_pw[1], 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
